// File: rtl/timer_host_master.sv
// Avalon-MM master that programs the interval timer, then services each timeout
// interrupt by reading and clearing its status; publishes a tick pulse and count.
module timer_host_master #(
    parameter logic [31:0] PERIOD_DEFAULT = 32'd49999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        period_sel,
    input  logic [31:0] period,
    output logic        busy,
    output logic        running,
    output logic        tick,
    output logic [31:0] tick_count,
    output logic        spurious_err,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_irq
);
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, RD_STAT, RD_WAIT,
        WR_CLR, HOLD, WR_STOP, WR_STOPCLR
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] period_reg, period_next;
    logic [31:0] tick_count_reg, tick_count_next;
    logic        spurious_reg, spurious_next;
    logic        running_reg, running_next;
    logic        stop_pend_reg, stop_pend_next;
    logic        accepted;
    logic        start_take;
    logic        unused_readdata;

    assign accepted        = !avm_waitrequest;
    assign unused_readdata = &{1'b0, avm_readdata[15:1]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            period_reg     <= '0;
            tick_count_reg <= '0;
            spurious_reg   <= 1'b0;
            running_reg    <= 1'b0;
            stop_pend_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            period_reg     <= period_next;
            tick_count_reg <= tick_count_next;
            spurious_reg   <= spurious_next;
            running_reg    <= running_next;
            stop_pend_reg  <= stop_pend_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        period_next     = period_reg;
        tick_count_next = tick_count_reg;
        spurious_next   = spurious_reg;
        running_next    = running_reg;
        stop_pend_next  = stop_pend_reg;
        start_take      = 1'b0;
        tick            = 1'b0;
        avm_chipselect  = 1'b0;
        avm_write_n     = 1'b1;
        avm_address     = 3'd0;
        avm_writedata   = 16'h0000;

        case (state_reg)
            IDLE: begin
                if (start) start_take = 1'b1;
            end
            WR_PL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = 3'd2;
                avm_writedata  = period_reg[15:0];
                if (accepted) state_next = WR_PH;
            end
            WR_PH: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = 3'd3;
                avm_writedata  = period_reg[31:16];
                if (accepted) state_next = WR_CTRL;
            end
            WR_CTRL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = 3'd1;
                avm_writedata  = 16'h0007;
                if (accepted) begin
                    running_next = 1'b1;
                    state_next   = RUN;
                end
            end
            RUN: begin
                if (avm_irq) begin
                    state_next = RD_STAT;
                end else if (stop || stop_pend_reg) begin
                    stop_pend_next = 1'b0;
                    state_next     = WR_STOP;
                end else if (start) begin
                    start_take = 1'b1;
                end
            end
            RD_STAT: begin
                avm_chipselect = 1'b1;
                avm_address    = 3'd0;
                if (accepted) state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (avm_readdata[0]) begin
                    tick            = 1'b1;
                    tick_count_next = tick_count_reg + 32'd1;
                end else begin
                    spurious_next = 1'b1;
                end
                state_next = WR_CLR;
            end
            WR_CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                if (accepted) state_next = HOLD;
            end
            HOLD: begin
                state_next = RUN;
            end
            WR_STOP: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = 3'd1;
                avm_writedata  = 16'h0008;
                if (accepted) begin
                    running_next = 1'b0;
                    state_next   = WR_STOPCLR;
                end
            end
            WR_STOPCLR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                if (accepted) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A stop that loses to an interrupt in RUN is remembered rather than dropped.
        if (stop && (state_reg != IDLE) && !(state_reg == RUN && !avm_irq))
            stop_pend_next = 1'b1;

        if (start_take) begin
            period_next     = period_sel ? period : PERIOD_DEFAULT;
            tick_count_next = '0;
            spurious_next   = 1'b0;
            stop_pend_next  = 1'b0;
            state_next      = WR_PL;
        end
    end

    assign busy         = (state_reg != IDLE) && (state_reg != RUN);
    assign running      = running_reg;
    assign tick_count   = tick_count_reg;
    assign spurious_err = spurious_reg;

endmodule

// File: tb/tb_timer_host_master.sv
// Randomized bench for timer_host_master: a behavioural interval-timer slave plus an
// event-level reference for ticks, tick count, spurious flag and the write stream.
module tb_timer_host_master;
    localparam logic [31:0] PDEF = 32'd29;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        period_sel = 1'b0;
    logic [31:0] period = '0;
    logic        busy, running, tick, spurious_err;
    logic [31:0] tick_count;
    logic [2:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        avm_waitrequest = 1'b0;
    logic        avm_irq;
    logic        force_irq = 1'b0;

    always #5 clk = ~clk;

    timer_host_master #(.PERIOD_DEFAULT(PDEF)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .period_sel(period_sel), .period(period), .busy(busy), .running(running),
        .tick(tick), .tick_count(tick_count), .spurious_err(spurious_err),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .avm_irq(avm_irq)
    );

    // Interval timer slave: counts down from its period, sets TO at zero and reloads.
    logic [31:0] tm_period, tm_cnt, wr_n, ref_total, ref_spur;
    logic        tm_run, tm_ito, tm_to, to_fire, rd_any, rd_to;
    logic [18:0] wr_log [0:4095];

    assign to_fire = tm_run && (tm_cnt == 32'd0);
    assign avm_irq = force_irq | (tm_to & tm_ito);

    always @(posedge clk) begin
        if (!reset_n) begin
            tm_period <= '0; tm_cnt <= '0; tm_run <= 1'b0; tm_ito <= 1'b0; tm_to <= 1'b0;
            rd_any <= 1'b0; rd_to <= 1'b0; ref_total <= '0; ref_spur <= '0; wr_n <= '0;
            avm_readdata <= '0;
        end else begin
            rd_any <= 1'b0;
            rd_to  <= 1'b0;
            if (tm_run) tm_cnt <= to_fire ? tm_period : tm_cnt - 32'd1;
            if (avm_chipselect && !avm_waitrequest) begin
                if (!avm_write_n) begin
                    wr_log[wr_n[11:0]] <= {avm_address, avm_writedata};
                    wr_n <= wr_n + 32'd1;
                    case (avm_address)
                        3'd0: tm_to <= 1'b0;
                        3'd1: begin
                            tm_ito <= avm_writedata[0];
                            if (avm_writedata[2]) begin
                                tm_run <= 1'b1;
                                tm_cnt <= tm_period;
                            end
                            if (avm_writedata[3]) tm_run <= 1'b0;
                        end
                        3'd2: begin tm_period[15:0]  <= avm_writedata; tm_run <= 1'b0; end
                        3'd3: begin tm_period[31:16] <= avm_writedata; tm_run <= 1'b0; end
                        default: ;
                    endcase
                end else begin
                    avm_readdata <= {15'd0, tm_to};
                    rd_any <= 1'b1;
                    rd_to  <= tm_to;
                    if (tm_to) ref_total <= ref_total + 32'd1;
                    else       ref_spur  <= ref_spur + 32'd1;
                end
            end
            if (to_fire) tm_to <= 1'b1;
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned cyc = 0;
    int          wait_hold = 0;
    bit          rand_wait = 1'b0;
    bit          chk_en = 1'b0;
    logic [31:0] count_base = '0, spur_base = '0, log_base = '0;
    logic        prev_stall = 1'b0;
    logic [20:0] prev_bus = '0;
    int unsigned tick_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        stop  = 1'b0;
        if (wait_hold > 0) begin
            avm_waitrequest = 1'b1;
            wait_hold--;
        end else begin
            avm_waitrequest = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        @(negedge clk);
        if (chk_en) begin
            check_eq("tick", {31'd0, tick}, {31'd0, rd_to});
            if (!rd_any) begin
                check_eq("tick_count", tick_count, ref_total - count_base);
                check_eq("spurious_err", {31'd0, spurious_err}, {31'd0, ref_spur != spur_base});
            end
            if (prev_stall)
                check_eq("bus_stable", {11'd0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
                         {11'd0, prev_bus});
            prev_stall = avm_chipselect && avm_waitrequest;
            prev_bus   = {avm_chipselect, avm_write_n, avm_address, avm_writedata};
            if (tick) tick_q.push_back(cyc);
        end
    endtask

    task automatic do_start(input logic sel, input logic [31:0] per);
        period_sel = sel;
        period     = per;
        start      = 1'b1;
        count_base = ref_total;
        spur_base  = ref_spur;
        log_base   = wr_n;
    endtask

    task automatic wait_running(input int lim);
        for (int i = 0; i < lim && running !== 1'b1; i++) step();
        check_eq("wait_running", {31'd0, running}, 32'd1);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && (busy !== 1'b0 || running !== 1'b0); i++) step();
        check_eq("wait_idle", {30'd0, busy, running}, 32'd0);
    endtask

    task automatic check_wr(input string tag, input logic [31:0] idx, input logic [2:0] a,
                            input logic [15:0] d);
        check_eq(tag, {13'd0, wr_log[idx[11:0]]}, {13'd0, a, d});
    endtask

    task automatic check_bus(input string tag, input logic [2:0] a, input logic [15:0] d);
        check_eq(tag, {11'd0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
                 {11'd0, 1'b1, 1'b0, a, d});
    endtask

    task automatic stop_and_idle();
        log_base = wr_n;
        stop = 1'b1;
        wait_idle(400);
        check_eq("stop_writes_present", (wr_n - log_base >= 32'd2) ? 32'd1 : 32'd0, 32'd1);
        check_wr("stop_ctrl_write", wr_n - 32'd2, 3'd1, 16'h0008);
        check_wr("stop_clr_write", wr_n - 32'd1, 3'd0, 16'h0000);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checked", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_p;
        int unsigned tq0;

        // Reset state
        reset_n = 1'b0;
        step(); step();
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_running", {31'd0, running}, 32'd0);
        check_eq("rst_tick", {31'd0, tick}, 32'd0);
        check_eq("rst_tick_count", tick_count, 32'd0);
        check_eq("rst_spurious", {31'd0, spurious_err}, 32'd0);
        check_eq("rst_chipselect", {31'd0, avm_chipselect}, 32'd0);
        check_eq("rst_write_n", {31'd0, avm_write_n}, 32'd1);
        check_eq("rst_address", {29'd0, avm_address}, 32'd0);
        check_eq("rst_writedata", {16'd0, avm_writedata}, 32'd0);
        reset_n = 1'b1;
        step();
        chk_en = 1'b1;

        // Programming order and timing
        do_start(1'b1, 32'h0001_0004);
        step(); check_bus("prog_c1_pl", 3'd2, 16'h0004);
        step(); check_bus("prog_c2_ph", 3'd3, 16'h0001);
        step(); check_bus("prog_c3_ctrl", 3'd1, 16'h0007);
        check_eq("prog_c3_running", {31'd0, running}, 32'd0);
        step();
        check_eq("prog_c4_running", {31'd0, running}, 32'd1);
        check_eq("prog_c4_busy", {31'd0, busy}, 32'd0);
        check_eq("prog_nwrites", wr_n - log_base, 32'd3);
        check_wr("prog_w0", log_base, 3'd2, 16'h0004);
        check_wr("prog_w1", log_base + 1, 3'd3, 16'h0001);
        check_wr("prog_w2", log_base + 2, 3'd1, 16'h0007);
        stop_and_idle();

        // Waitrequest stall during WR_PH
        do_start(1'b1, 32'h0002_0013);
        step(); check_bus("stall_pl", 3'd2, 16'h0013);
        wait_hold = 3;
        for (int i = 0; i < 4; i++) begin
            step();
            check_bus("stall_ph_hold", 3'd3, 16'h0002);
        end
        step(); check_bus("stall_ctrl_next", 3'd1, 16'h0007);
        step();
        check_eq("stall_nwrites", wr_n - log_base, 32'd3);
        check_wr("stall_w1", log_base + 1, 3'd3, 16'h0002);
        stop_and_idle();

        // Periodic ticks, period 19
        do_start(1'b1, 32'd19);
        wait_running(50);
        tick_q.delete();
        for (int i = 0; i < 400 && tick_q.size() < 10; i++) step();
        check_eq("periodic_npulses", tick_q.size(), 32'd10);
        step();
        check_eq("periodic_count10", tick_count, 32'd10);
        check_eq("periodic_spurious", {31'd0, spurious_err}, 32'd0);
        step();
        for (int i = 1; i < tick_q.size(); i++)
            check_eq("tick_interval", tick_q[i] - tick_q[i-1], 32'd20);
        check_eq("periodic_nwrites", wr_n - log_base, 32'd13);
        for (int i = 3; i < 13; i++) check_wr("periodic_clr", log_base + i, 3'd0, 16'h0000);

        // Stop arriving in the RD_STAT cycle
        for (int i = 0; i < 40 && !(avm_chipselect && avm_write_n); i++) step();
        check_eq("svc_in_rdstat", {29'd0, avm_chipselect, avm_write_n, avm_address[0]}, 32'd6);
        tq0 = tick_q.size();
        log_base = wr_n;
        stop = 1'b1;
        wait_idle(60);
        check_eq("svc_tick_seen", tick_q.size() - tq0, 32'd1);
        check_eq("svc_nwrites", wr_n - log_base, 32'd3);
        check_wr("svc_clr", log_base, 3'd0, 16'h0000);
        check_wr("svc_stop", log_base + 1, 3'd1, 16'h0008);
        check_wr("svc_stopclr", log_base + 2, 3'd0, 16'h0000);

        // Spurious interrupt with status TO=0
        do_start(1'b1, 32'd1000);
        wait_running(50);
        tq0 = tick_q.size();
        force_irq = 1'b1;
        step();
        force_irq = 1'b0;
        repeat (6) step();
        check_eq("spur_flag", {31'd0, spurious_err}, 32'd1);
        check_eq("spur_count", tick_count, 32'd0);
        check_eq("spur_no_tick", tick_q.size() - tq0, 32'd0);
        check_eq("spur_nwrites", wr_n - log_base, 32'd4);
        check_wr("spur_clr", log_base + 3, 3'd0, 16'h0000);
        stop_and_idle();

        // Default period source
        do_start(1'b0, 32'h0000_0100);
        wait_running(50);
        check_wr("default_pl", log_base, 3'd2, PDEF[15:0]);
        tick_q.delete();
        for (int i = 0; i < 200 && tick_q.size() < 3; i++) step();
        check_eq("default_npulses", tick_q.size(), 32'd3);
        for (int i = 1; i < tick_q.size(); i++)
            check_eq("default_interval", tick_q[i] - tick_q[i-1], PDEF + 32'd1);
        stop_and_idle();

        // Randomized runs with random stalls
        rand_wait = 1'b1;
        for (int it = 0; it < 6; it++) begin
            logic        sel;
            logic [31:0] per;
            sel = 1'($urandom_range(0, 1));
            per = sel ? 32'($urandom_range(5, 40)) : $urandom();
            exp_p = sel ? per : PDEF;
            do_start(sel, per);
            wait_running(100);
            check_wr("rand_pl", log_base, 3'd2, exp_p[15:0]);
            check_wr("rand_ph", log_base + 1, 3'd3, exp_p[31:16]);
            check_wr("rand_ctrl", log_base + 2, 3'd1, 16'h0007);
            repeat ($urandom_range(150, 300)) step();
            stop_and_idle();
            $display("run %0d: period 0x%08h, tick_count %0d, spurious %0d", it, exp_p,
                     tick_count, spurious_err);
        end
        rand_wait = 1'b0;

        // Reset during a stalled WR_PH of a restart issued from RUN
        do_start(1'b1, 32'h0003_0005);
        wait_running(50);
        do_start(1'b1, 32'h0004_0006);
        step(); check_bus("rst_mid_pl", 3'd2, 16'h0006);
        wait_hold = 3;
        step(); check_bus("rst_mid_ph", 3'd3, 16'h0004);
        check_eq("rst_mid_running_before", {31'd0, running}, 32'd1);
        chk_en = 1'b0;
        reset_n = 1'b0;
        step();
        check_eq("rst_mid_chipselect", {31'd0, avm_chipselect}, 32'd0);
        check_eq("rst_mid_write_n", {31'd0, avm_write_n}, 32'd1);
        check_eq("rst_mid_running", {31'd0, running}, 32'd0);
        check_eq("rst_mid_tick_count", tick_count, 32'd0);
        check_eq("rst_mid_idle", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        wait_hold = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
